// File: rtl/div_pkg.sv
// Shared types and constants for the 8-by-4 restoring divider tile.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DVD_W = 8;
  localparam int DEF_DVS_W = 4;
  localparam int N_ITER    = DEF_DVD_W;

  localparam logic [DEF_DVD_W-1:0] DIV0_QUO = '1;

endpackage

// File: rtl/divider_core.sv
// Restoring divider: one quotient bit per clock, start/done/err handshake.
module divider_core
  import div_pkg::*;
#(
  parameter int DVD_W = DEF_DVD_W,
  parameter int DVS_W = DEF_DVS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             launch,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(DVD_W);

  state_t           state_q, state_d;
  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             last;
  logic [DVS_W:0]   rem_shift;
  logic [DVS_W+1:0] diff;
  logic             fits;
  logic [DVS_W:0]   rem_next;
  logic [DVD_W-1:0] quo_next;

  assign accept = launch && (state_q != CALC);
  assign last   = (cnt_q == CNT_W'(DVD_W - 1));

  // rem never exceeds the divisor, so its top bit can be dropped on the shift.
  assign rem_shift = {rem_q[DVS_W-1:0], dvd_q[DVD_W-1]};
  assign diff      = {1'b0, rem_shift} - {2'b00, dvs_q};
  assign fits      = ~diff[DVS_W+1];
  assign rem_next  = fits ? diff[DVS_W:0] : rem_shift;
  assign quo_next  = {dvd_q[DVD_W-2:0], fits};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default assigned first so no path through the case leaves state_d
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (accept) state_d = CALC;
      CALC:       if (last)   state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (accept) begin
      dvd_q <= dividend;
      dvs_q <= divisor;
      rem_q <= '0;
      cnt_q <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else if (state_q == CALC) begin
      dvd_q <= quo_next;
      rem_q <= rem_next;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        // With a zero divisor every trial "fits" without changing rem, so
        // rem ends up holding the low dividend bits -- exactly the forced remainder.
        quotient  <= (dvs_q == '0) ? DVD_W'(DIV0_QUO) : quo_next;
        remainder <= rem_next[DVS_W-1:0];
        err       <= (dvs_q == '0);
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tt_um_div8x4.sv
// TinyTapeout wrapper: start edge detect, pin mapping and result display mux.
module tt_um_div8x4
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       start_q;
  logic       launch;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       done;
  logic       err;
  logic       unused_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= uio_in[4];
  end

  assign launch = uio_in[4] & ~start_q;

  divider_core #(
    .DVD_W(DEF_DVD_W),
    .DVS_W(DEF_DVS_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .launch   (launch),
    .dividend (ui_in),
    .divisor  (uio_in[3:0]),
    .quotient (quotient),
    .remainder(remainder),
    .done     (done),
    .err      (err)
  );

  assign uo_out    = uio_in[5] ? {4'b0000, remainder} : quotient;
  assign uio_out   = {done, err, 6'b000000};
  assign uio_oe    = 8'b1100_0000;
  assign unused_ok = &{1'b0, ena, uio_in[7:6]};

endmodule

// File: tb/tb_tt_um_div8x4.sv
// Self-checking bench for tt_um_div8x4 against an arithmetic reference model.
module tb_tt_um_div8x4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [3:0] dvs_in = '0;
  logic       start_in = 1'b0;
  logic       sel_in = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int failures = 0;

  assign uio_in = {2'b00, sel_in, start_in, dvs_in};

  tt_um_div8x4 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain unsigned division with the divide-by-zero rule.
  function automatic logic [7:0] model_q(input logic [7:0] a, input logic [3:0] b);
    return (b == 0) ? 8'hFF : 8'(a / b);
  endfunction

  function automatic logic [3:0] model_r(input logic [7:0] a, input logic [3:0] b);
    return (b == 0) ? a[3:0] : 4'(a % b);
  endfunction

  // Rising start edge with operands; returns at the negedge after the launch edge.
  task automatic launch(input logic [7:0] a, input logic [3:0] b, input bit hold);
    @(negedge clk);
    ui_in    = a;
    dvs_in   = b;
    start_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("done_clear_on_launch", {31'd0, uio_out[7]}, 32'd0);
    if (!hold) start_in = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!uio_out[7] && lat < 20);
    check({tag, "_latency"}, lat, 8);
  endtask

  task automatic check_results(input string tag, input logic [7:0] a, input logic [3:0] b);
    sel_in = 1'b0;
    #1 check({tag, "_quotient"}, {24'd0, uo_out}, {24'd0, model_q(a, b)});
    sel_in = 1'b1;
    #1 check({tag, "_remainder"}, {24'd0, uo_out}, {28'd0, model_r(a, b)});
    check({tag, "_flags"}, {24'd0, uio_out}, {24'd0, 1'b1, (b == 0), 6'd0});
    sel_in = 1'b0;
  endtask

  initial begin
    logic [7:0] a;
    logic [3:0] b;

    // Reset state
    #12;
    check("reset_uo_out", {24'd0, uo_out}, 32'd0);
    check("reset_uio_out", {24'd0, uio_out}, 32'd0);
    check("uio_oe", {24'd0, uio_oe}, 32'hC0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic divisions
    launch(8'd200, 4'd7, 0);
    wait_done("d200_7");
    check_results("d200_7", 8'd200, 4'd7);
    launch(8'd255, 4'd1, 0);
    wait_done("d255_1");
    check_results("d255_1", 8'd255, 4'd1);
    launch(8'd13, 4'd15, 0);
    wait_done("d13_15");
    check_results("d13_15", 8'd13, 4'd15);

    // Divide by zero, then a valid division clears err
    launch(8'hA5, 4'd0, 0);
    wait_done("dA5_0");
    check_results("dA5_0", 8'hA5, 4'd0);
    launch(8'hA5, 4'd3, 0);
    wait_done("dA5_3");
    check_results("dA5_3", 8'hA5, 4'd3);

    // Start toggling and operand changes during CALC are ignored
    launch(8'd100, 4'd9, 0);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("d100_9_done_e%0d", i), {31'd0, uio_out[7]}, {31'd0, (i == 8)});
      if (i <= 5) begin
        start_in = i[0];
        ui_in    = 8'($urandom);
        dvs_in   = 4'($urandom);
      end else begin
        start_in = 1'b0;
      end
    end
    check_results("d100_9", 8'd100, 4'd9);

    // Reset in the middle of a computation; previous result shown until then
    launch(8'd77, 4'd5, 0);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("calc_holds_prev", {24'd0, uo_out}, 32'd11);
    rst_n = 1'b0;
    #1 check("midcalc_rst_uo_out", {24'd0, uo_out}, 32'd0);
    check("midcalc_rst_uio_out", {24'd0, uio_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(8'd50, 4'd6, 0);
    wait_done("d50_6");
    check_results("d50_6", 8'd50, 4'd6);

    // Start held high for 30 cycles: exactly one computation
    launch(8'd222, 4'd11, 1);
    wait_done("held");
    repeat (21) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("held_no_relaunch_done", {31'd0, uio_out[7]}, 32'd1);
    check_results("held", 8'd222, 4'd11);
    start_in = 1'b0;
    launch(8'd123, 4'd4, 0);
    wait_done("relaunch");
    check_results("relaunch", 8'd123, 4'd4);

    // Start already high when reset is released launches on the first edge
    @(negedge clk);
    rst_n    = 1'b0;
    ui_in    = 8'd90;
    dvs_in   = 4'd13;
    start_in = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_in = 1'b0;
    wait_done("rst_start");
    check_results("rst_start", 8'd90, 4'd13);

    // Randomized operands against the model
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = 4'($urandom_range(0, 15));
      launch(a, b, 0);
      wait_done($sformatf("rnd%0d", i));
      check_results($sformatf("rnd%0d_%0d_%0d", i, a, b), a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
